multi_hot_count_unit: RTL and testbench

- Registered population-count and multi-hot detector for a flat bit vector of request/grant flags.
- Used in allocator/arbiter control paths to flag illegal multi-hot grant vectors and report how many bits are set.
- Two independent combinational structures feed one register stage:
  - an n-to-1 adder of 1-bit inputs (popcount);
  - a multi-hot detector that does not use the adder (OR/AND reduction tree).
- The two structures are functionally redundant, so count > 1 must always equal multi_hot.

---
 rtl/multi_hot_count_unit.sv | 78 +++++++
 tb/tb_multi_hot_count_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multi_hot_count_unit.sv
// Registered population count and multi-hot detector for a flat flag vector.
// A balanced adder tree and an independent OR/AND reduction tree feed one register stage.
module multi_hot_count_unit #(
  parameter  int width     = 5,
  localparam int cnt_width = $clog2(width + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic [0:width-1]     data,
  output logic [0:cnt_width-1] count,
  output logic                 multi_hot,
  output logic                 any_hot
);

  localparam int LEVELS = (width > 1) ? $clog2(width) : 0;
  // Level l partial sums need l+1 bits; storage is sized for the root.
  localparam int SW     = LEVELS + 1;

  logic [SW-1:0]        w_sum   [0:LEVELS][0:width-1];
  logic                 w_any   [0:LEVELS][0:width-1];
  logic                 w_multi [0:LEVELS][0:width-1];
  logic [cnt_width-1:0] w_cnt_next;

  logic [cnt_width-1:0] r_count;
  logic                 r_multi_hot;
  logic                 r_any_hot;

  genvar l, j;
  generate
    for (j = 0; j < width; j++) begin : g_leaf
      assign w_sum[0][j]   = SW'(data[j]);
      assign w_any[0][j]   = data[j];
      assign w_multi[0][j] = 1'b0;
    end

    for (l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int N_PREV = (width + (1 << (l - 1)) - 1) >> (l - 1);
      for (j = 0; j < width; j++) begin : g_node
        if (2 * j + 1 < N_PREV) begin : g_pair
          assign w_sum[l][j]   = w_sum[l-1][2*j] + w_sum[l-1][2*j+1];
          assign w_any[l][j]   = w_any[l-1][2*j] | w_any[l-1][2*j+1];
          assign w_multi[l][j] = w_multi[l-1][2*j] | w_multi[l-1][2*j+1]
                               | (w_any[l-1][2*j] & w_any[l-1][2*j+1]);
        end else if (2 * j + 1 == N_PREV) begin : g_pass
          // Unpaired last node of an odd-sized level moves up unchanged.
          assign w_sum[l][j]   = w_sum[l-1][2*j];
          assign w_any[l][j]   = w_any[l-1][2*j];
          assign w_multi[l][j] = w_multi[l-1][2*j];
        end else begin : g_empty
          assign w_sum[l][j]   = '0;
          assign w_any[l][j]   = 1'b0;
          assign w_multi[l][j] = 1'b0;
        end
      end
    end
  endgenerate

  // Root sum never exceeds width, so resizing to cnt_width is lossless.
  assign w_cnt_next = cnt_width'(w_sum[LEVELS][0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_multi_hot <= 1'b0;
      r_any_hot   <= 1'b0;
    end else if (active) begin
      r_count     <= w_cnt_next;
      r_multi_hot <= w_multi[LEVELS][0];
      r_any_hot   <= w_any[LEVELS][0];
    end
  end

  assign count     = r_count;
  assign multi_hot = r_multi_hot;
  assign any_hot   = r_any_hot;

endmodule

// File: tb/tb_multi_hot_count_unit.sv
// Self-checking bench for multi_hot_count_unit: table vectors and scoreboard on width 5,
// hand sequences for latency/hold/async reset, and a sweep over widths 1, 2, 8, 16.
module tb_multi_hot_count_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       active;
  logic       act_sw;
  logic [0:4] data5;
  logic [0:2] cnt5;
  logic       m5, a5;

  logic [0:0]  d1;  logic [0:0] c1; logic m1, a1;
  logic [0:1]  d2;  logic [0:1] c2; logic m2, a2;
  logic [0:7]  d8;  logic [0:3] c8; logic m8, a8;
  logic [0:15] d16; logic [0:4] c16; logic m16, a16;

  multi_hot_count_unit #(.width(5)) dut5 (
    .clk(clk), .reset(reset), .active(active), .data(data5),
    .count(cnt5), .multi_hot(m5), .any_hot(a5));
  multi_hot_count_unit #(.width(1)) dut1 (
    .clk(clk), .reset(reset), .active(act_sw), .data(d1),
    .count(c1), .multi_hot(m1), .any_hot(a1));
  multi_hot_count_unit #(.width(2)) dut2 (
    .clk(clk), .reset(reset), .active(act_sw), .data(d2),
    .count(c2), .multi_hot(m2), .any_hot(a2));
  multi_hot_count_unit #(.width(8)) dut8 (
    .clk(clk), .reset(reset), .active(act_sw), .data(d8),
    .count(c8), .multi_hot(m8), .any_hot(a8));
  multi_hot_count_unit #(.width(16)) dut16 (
    .clk(clk), .reset(reset), .active(act_sw), .data(d16),
    .count(c16), .multi_hot(m16), .any_hot(a16));

  typedef struct {
    logic [4:0] d;
    logic       act;
    int         c;
    bit         m;
    bit         a;
    string      name;
  } vec_t;

  typedef struct {
    int    c;
    bit    m;
    bit    a;
    string name;
  } exp_t;

  vec_t vec [0:11];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(string name, logic [31:0] gc, logic gm, logic ga,
                     int ec, bit em, bit ea);
    n_cmp++;
    if (gc !== ec || gm !== em || ga !== ea) begin
      n_mis++;
      $display("FAIL %s: got count=%0d multi=%b any=%b, want count=%0d multi=%0d any=%0d",
               name, gc, gm, ga, ec, em, ea);
    end
  endtask

  task automatic drive(logic [4:0] d, logic act, int ec, bit em, bit ea, string name);
    exp_t e;
    @(negedge clk);
    data5  = d;
    active = act;
    e.c = ec; e.m = em; e.a = ea; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: scoreboard empty at output time", name);
    end else begin
      e = sb.pop_front();
      chk(e.name, 32'(cnt5), m5, a5, e.c, e.m, e.a);
    end
  endtask

  task automatic chk_sweep();
    chk("w1",  32'(c1),  m1,  a1,  $countones(d1),  $countones(d1)  > 1, d1  != 0);
    chk("w2",  32'(c2),  m2,  a2,  $countones(d2),  $countones(d2)  > 1, d2  != 0);
    chk("w8",  32'(c8),  m8,  a8,  $countones(d8),  $countones(d8)  > 1, d8  != 0);
    chk("w16", 32'(c16), m16, a16, $countones(d16), $countones(d16) > 1, d16 != 0);
  endtask

  initial begin
    logic [4:0] dv;
    int         pc;

    vec[0]  = '{5'b00000, 1'b1, 0, 1'b0, 1'b0, "v_zero"};
    vec[1]  = '{5'b00100, 1'b1, 1, 1'b0, 1'b1, "v_one"};
    vec[2]  = '{5'b10001, 1'b1, 2, 1'b1, 1'b1, "v_two"};
    vec[3]  = '{5'b11111, 1'b1, 5, 1'b1, 1'b1, "v_all"};
    vec[4]  = '{5'b01110, 1'b1, 3, 1'b1, 1'b1, "v_three"};
    vec[5]  = '{5'b00000, 1'b0, 3, 1'b1, 1'b1, "hold_1"};
    vec[6]  = '{5'b00000, 1'b0, 3, 1'b1, 1'b1, "hold_2"};
    vec[7]  = '{5'b00000, 1'b0, 3, 1'b1, 1'b1, "hold_3"};
    vec[8]  = '{5'b01000, 1'b1, 1, 1'b0, 1'b1, "v_single"};
    vec[9]  = '{5'b11011, 1'b0, 1, 1'b0, 1'b1, "hold_4"};
    vec[10] = '{5'b11011, 1'b1, 4, 1'b1, 1'b1, "v_four"};
    vec[11] = '{5'b10000, 1'b1, 1, 1'b0, 1'b1, "v_msb"};

    reset  = 1'b1;
    active = 1'b1;
    act_sw = 1'b1;
    data5  = 5'b11111;
    d1 = '1; d2 = '1; d8 = '1; d16 = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w5",  32'(cnt5), m5,  a5,  0, 1'b0, 1'b0);
    chk("reset_w16", 32'(c16),  m16, a16, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      drive(vec[i].d, vec[i].act, vec[i].c, vec[i].m, vec[i].a, vec[i].name);

    // Latency: new data must not show before the capturing edge.
    drive(5'b00000, 1'b1, 0, 1'b0, 1'b0, "lat_base");
    @(negedge clk);
    data5  = 5'b00011;
    active = 1'b1;
    #1;
    chk("lat_pre", 32'(cnt5), m5, a5, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_post", 32'(cnt5), m5, a5, 2, 1'b1, 1'b1);

    // Asynchronous reset pulse between edges.
    drive(5'b11111, 1'b1, 5, 1'b1, 1'b1, "rst_pre");
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_async", 32'(cnt5), m5, a5, 0, 1'b0, 1'b0);
    active = 1'b0;
    data5  = 5'b01000;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold", 32'(cnt5), m5, a5, 0, 1'b0, 1'b0);
    drive(5'b01000, 1'b1, 1, 1'b0, 1'b1, "rst_after");

    for (int v = 0; v < 32; v++) begin
      dv = 5'(v);
      pc = $countones(dv);
      drive(dv, 1'b1, pc, pc > 1, pc != 0, "exh_w5");
    end

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      d1  = 1'(i);
      d2  = 2'(i);
      d8  = 8'(i);
      d16 = 16'($urandom);
      @(posedge clk);
      #1;
      chk_sweep();
    end

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      d16 = (i == 0) ? 16'hFFFF : 16'($urandom);
      @(posedge clk);
      #1;
      chk("w16_rand", 32'(c16), m16, a16,
          $countones(d16), $countones(d16) > 1, d16 != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
